// File: rtl/ysyx_22041071_axi_w.sv
// ysyx_22041071_axi_w: AXI4 write master, one request at a time through AW, W and B.
// Single beats are byte-lane aligned from addr/size; INCR bursts pass full-width beats.
module ysyx_22041071_axi_w #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 64,
  parameter int ID_WIDTH   = 4,
  parameter int LEN_WIDTH  = 8
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    cpu_aw_valid,
  output logic                    cpu_aw_ready,
  input  logic [ID_WIDTH-1:0]     cpu_id,
  input  logic [ADDR_WIDTH-1:0]   cpu_addr,
  input  logic [LEN_WIDTH-1:0]    cpu_len,
  input  logic [1:0]              cpu_size,
  input  logic                    cpu_w_valid,
  input  logic [DATA_WIDTH-1:0]   cpu_w_data,
  output logic                    cpu_w_ready,
  output logic                    cpu_b_valid,
  output logic [1:0]              cpu_b_resp,
  input  logic                    axi_aw_ready_i,
  output logic                    axi_aw_valid_o,
  output logic [ID_WIDTH-1:0]     axi_aw_id_o,
  output logic [ADDR_WIDTH-1:0]   axi_aw_addr_o,
  output logic [LEN_WIDTH-1:0]    axi_aw_len_o,
  output logic [2:0]              axi_aw_size_o,
  output logic [1:0]              axi_aw_burst_o,
  output logic [2:0]              axi_aw_prot_o,
  output logic [3:0]              axi_aw_cache_o,
  output logic [3:0]              axi_aw_qos_o,
  output logic [3:0]              axi_aw_region_o,
  output logic                    axi_aw_lock_o,
  output logic                    axi_aw_user_o,
  input  logic                    axi_w_ready_i,
  output logic                    axi_w_valid_o,
  output logic [DATA_WIDTH-1:0]   axi_w_data_o,
  output logic [DATA_WIDTH/8-1:0] axi_w_strb_o,
  output logic                    axi_w_last_o,
  input  logic                    axi_b_valid_i,
  output logic                    axi_b_ready_o,
  input  logic [1:0]              axi_b_resp_i,
  input  logic [ID_WIDTH-1:0]     axi_b_id_i
);
  localparam int SW = DATA_WIDTH / 8;
  localparam logic [1:0] IDLE = 2'd0, ADDR = 2'd1, DATA = 2'd2, RESP = 2'd3;

  logic [1:0]            r_state;
  logic [ID_WIDTH-1:0]   r_id;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [LEN_WIDTH-1:0]  r_len;
  logic [LEN_WIDTH-1:0]  r_beat_cnt;
  logic [1:0]            r_size;
  logic                  r_b_valid;
  logic [1:0]            r_b_resp;
  logic                  w_in_data;
  logic                  w_w_hs;
  logic                  w_single;
  logic [7:0]            w_base;
  logic [7:0]            w_strb;
  logic                  w_unused;

  assign w_in_data      = r_state == DATA;
  assign cpu_aw_ready   = r_state == IDLE;
  assign axi_aw_valid_o = r_state == ADDR;
  assign axi_b_ready_o  = r_state == RESP;
  assign axi_aw_id_o    = r_id;
  assign axi_aw_addr_o  = {r_addr[ADDR_WIDTH-1:3], 3'b000};
  assign axi_aw_len_o   = r_len;
  assign axi_aw_size_o  = {1'b0, r_size};
  assign axi_aw_burst_o = 2'b01;
  assign axi_aw_prot_o   = '0;
  assign axi_aw_cache_o  = '0;
  assign axi_aw_qos_o    = '0;
  assign axi_aw_region_o = '0;
  assign axi_aw_lock_o   = 1'b0;
  assign axi_aw_user_o   = 1'b0;
  assign axi_w_valid_o = w_in_data & cpu_w_valid;
  assign cpu_w_ready   = w_in_data & axi_w_ready_i;
  assign axi_w_last_o  = w_in_data & (r_beat_cnt == r_len);
  assign w_w_hs        = axi_w_valid_o & axi_w_ready_i;
  assign cpu_b_valid   = r_b_valid;
  assign cpu_b_resp    = r_b_resp;
  assign w_unused      = ^axi_b_id_i;

  // Single beats land on their byte lanes; lanes past the 8-byte boundary are dropped.
  assign w_single     = r_len == '0;
  assign w_base       = r_size == 2'd0 ? 8'h01 : r_size == 2'd1 ? 8'h03 : r_size == 2'd2 ? 8'h0F : 8'hFF;
  assign w_strb       = w_base << r_addr[2:0];
  assign axi_w_data_o = w_single ? cpu_w_data << {r_addr[2:0], 3'b000} : cpu_w_data;
  assign axi_w_strb_o = w_single ? SW'(w_strb) : '1;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state    <= IDLE;
      r_id       <= '0;
      r_addr     <= '0;
      r_len      <= '0;
      r_size     <= '0;
      r_beat_cnt <= '0;
      r_b_valid  <= 1'b0;
      r_b_resp   <= 2'b00;
    end else begin
      r_b_valid <= 1'b0;
      case (r_state)
        IDLE: if (cpu_aw_valid) begin
          r_state    <= ADDR;
          r_id       <= cpu_id;
          r_addr     <= cpu_addr;
          r_len      <= cpu_len;
          r_size     <= cpu_size;
          r_beat_cnt <= '0;
        end
        ADDR: if (axi_aw_ready_i) r_state <= DATA;
        DATA: if (w_w_hs) begin
          if (axi_w_last_o) r_state <= RESP;
          else r_beat_cnt <= r_beat_cnt + 1'b1;
        end
        default: if (axi_b_valid_i) begin
          r_state   <= IDLE;
          r_b_valid <= 1'b1;
          r_b_resp  <= axi_b_resp_i;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_ysyx_22041071_axi_w.sv
// tb_ysyx_22041071_axi_w: scoreboard bench; driver pushes expected AW/W/B, monitor pops and compares.
module tb_ysyx_22041071_axi_w;
  logic        clk, reset_n;
  logic        cpu_aw_valid, cpu_aw_ready, cpu_w_valid, cpu_w_ready, cpu_b_valid;
  logic [3:0]  cpu_id;
  logic [63:0] cpu_addr, cpu_w_data;
  logic [7:0]  cpu_len;
  logic [1:0]  cpu_size, cpu_b_resp;
  logic        axi_aw_ready_i, axi_aw_valid_o, axi_aw_lock_o, axi_aw_user_o;
  logic [3:0]  axi_aw_id_o, axi_aw_cache_o, axi_aw_qos_o, axi_aw_region_o;
  logic [63:0] axi_aw_addr_o, axi_w_data_o;
  logic [7:0]  axi_aw_len_o, axi_w_strb_o;
  logic [2:0]  axi_aw_size_o, axi_aw_prot_o;
  logic [1:0]  axi_aw_burst_o, axi_b_resp_i;
  logic        axi_w_ready_i, axi_w_valid_o, axi_w_last_o, axi_b_valid_i, axi_b_ready_o;
  logic [3:0]  axi_b_id_i;

  ysyx_22041071_axi_w dut (
    .clk(clk), .reset_n(reset_n),
    .cpu_aw_valid(cpu_aw_valid), .cpu_aw_ready(cpu_aw_ready), .cpu_id(cpu_id),
    .cpu_addr(cpu_addr), .cpu_len(cpu_len), .cpu_size(cpu_size),
    .cpu_w_valid(cpu_w_valid), .cpu_w_data(cpu_w_data), .cpu_w_ready(cpu_w_ready),
    .cpu_b_valid(cpu_b_valid), .cpu_b_resp(cpu_b_resp),
    .axi_aw_ready_i(axi_aw_ready_i), .axi_aw_valid_o(axi_aw_valid_o), .axi_aw_id_o(axi_aw_id_o),
    .axi_aw_addr_o(axi_aw_addr_o), .axi_aw_len_o(axi_aw_len_o), .axi_aw_size_o(axi_aw_size_o),
    .axi_aw_burst_o(axi_aw_burst_o), .axi_aw_prot_o(axi_aw_prot_o), .axi_aw_cache_o(axi_aw_cache_o),
    .axi_aw_qos_o(axi_aw_qos_o), .axi_aw_region_o(axi_aw_region_o), .axi_aw_lock_o(axi_aw_lock_o),
    .axi_aw_user_o(axi_aw_user_o),
    .axi_w_ready_i(axi_w_ready_i), .axi_w_valid_o(axi_w_valid_o), .axi_w_data_o(axi_w_data_o),
    .axi_w_strb_o(axi_w_strb_o), .axi_w_last_o(axi_w_last_o),
    .axi_b_valid_i(axi_b_valid_i), .axi_b_ready_o(axi_b_ready_o), .axi_b_resp_i(axi_b_resp_i),
    .axi_b_id_i(axi_b_id_i)
  );

  typedef struct { logic [63:0] addr; logic [7:0] len; logic [2:0] size; logic [3:0] id; } aw_t;
  typedef struct { logic [63:0] data; logic [7:0] strb; logic last; } w_t;
  typedef struct { logic [1:0] resp; int dly; } b_t;

  aw_t        eaw[$];
  w_t         ew[$];
  logic [1:0] eb[$];
  b_t         sq[$];
  int n_chk = 0, n_fail = 0;
  logic rnd_ready = 0, w_toggle = 0, early_b = 0;
  int aw_hold = 0;

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s", name);
  endtask

  // Reference: place the low (1<<size) bytes of d starting at lane addr%8, dropping overflow lanes.
  function automatic w_t model_beat(input logic [63:0] addr, input logic [1:0] size,
                                    input logic [7:0] len, input logic [63:0] d, input logic last);
    w_t r;
    int off;
    r.last = last;
    if (len != 0) begin
      r.data = d;
      r.strb = 8'hFF;
      return r;
    end
    off = int'(addr[2:0]);
    r.data = '0;
    r.strb = '0;
    for (int j = off; j < 8; j++) r.data[8*j +: 8] = d[8*(j-off) +: 8];
    for (int b = 0; b < (1 << size); b++) if (off + b < 8) r.strb[off+b] = 1'b1;
    return r;
  endfunction

  task automatic rst_checks();
    chk("rst_aw_valid", axi_aw_valid_o, 0);
    chk("rst_w_valid", axi_w_valid_o, 0);
    chk("rst_w_last", axi_w_last_o, 0);
    chk("rst_b_ready", axi_b_ready_o, 0);
    chk("rst_cpu_aw_ready", cpu_aw_ready, 1);
    chk("rst_cpu_w_ready", cpu_w_ready, 0);
    chk("rst_cpu_b_valid", cpu_b_valid, 0);
    chk("rst_cpu_b_resp", cpu_b_resp, 0);
    chk("rst_aw_fields", {axi_aw_addr_o, axi_aw_len_o, axi_aw_size_o, axi_aw_id_o}, 0);
  endtask

  task automatic do_reset();
    reset_n = 0;
    @(posedge clk); #1;
    eaw.delete(); ew.delete(); eb.delete(); sq.delete();
    rst_checks();
    cpu_w_valid = 0;
    cpu_aw_valid = 0;
    reset_n = 1;
  endtask

  task automatic issue(input logic [3:0] id, input logic [63:0] addr, input logic [1:0] size,
                       input logic [7:0] len, input logic [1:0] resp, input int dly,
                       input int rst_beat, input logic bub, input logic fixed, input logic [63:0] d0);
    logic [63:0] beats[$];
    int t;
    logic hs;
    for (int k = 0; k <= int'(len); k++) begin
      beats.push_back((k == 0 && fixed) ? d0 : {$urandom, $urandom});
      ew.push_back(model_beat(addr, size, len, beats[k], k == int'(len)));
    end
    eaw.push_back('{addr: {addr[63:3], 3'b000}, len: len, size: {1'b0, size}, id: id});
    eb.push_back(resp);
    sq.push_back('{resp: resp, dly: dly});
    cpu_aw_valid = 1; cpu_id = id; cpu_addr = addr; cpu_size = size; cpu_len = len;
    t = 0;
    forever begin
      @(negedge clk);
      if (cpu_aw_ready) break;
      @(posedge clk); #1;
      t++;
      if (t > 300) begin fail("aw_accept_timeout"); cpu_aw_valid = 0; return; end
    end
    @(posedge clk); #1;
    // Junk request fields while busy: none of it may be latched.
    cpu_aw_valid = 1'($urandom_range(0, 1));
    cpu_addr = {$urandom, $urandom}; cpu_len = 8'($urandom); cpu_size = 2'($urandom); cpu_id = 4'($urandom);
    for (int k = 0; k <= int'(len); k++) begin
      cpu_w_data = beats[k];
      t = 0;
      forever begin
        cpu_w_valid = bub ? ($urandom_range(0, 2) != 0) : 1'b1;
        if (k == rst_beat) begin do_reset(); return; end
        @(negedge clk);
        hs = cpu_w_valid && cpu_w_ready;
        @(posedge clk); #1;
        if (hs) break;
        t++;
        if (t > 300) begin fail("w_timeout"); cpu_w_valid = 0; cpu_aw_valid = 0; return; end
      end
    end
    cpu_w_valid = 0;
    cpu_aw_valid = 0;
  endtask

  task automatic drain();
    int t = 0;
    while (eb.size() != 0 && t < 500) begin @(posedge clk); #1; t++; end
    if (eb.size() != 0) fail("drain_timeout");
    repeat (2) @(posedge clk);
    #1;
    chk("queues_empty", eaw.size() + ew.size() + eb.size(), 0);
  endtask

  // AXI slave: readiness per mode, B after a per-transaction delay once the last beat is seen.
  initial begin
    logic armed = 0, aw_ok = 0, tog = 0;
    int cd = 0, aw_wait = 0;
    axi_aw_ready_i = 0; axi_w_ready_i = 0; axi_b_valid_i = 0; axi_b_resp_i = 0; axi_b_id_i = 0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        armed = 0; aw_ok = 0; aw_wait = 0; cd = 0;
      end else begin
        if (axi_aw_valid_o) begin
          if (axi_aw_ready_i) begin aw_ok = 1; aw_wait = 0; end
          else aw_wait++;
        end
        if (axi_w_valid_o && axi_w_ready_i && axi_w_last_o) begin
          armed = 1;
          cd = sq.size() != 0 ? sq[0].dly : 0;
        end else if (axi_b_valid_i && axi_b_ready_o) begin
          if (sq.size() != 0) void'(sq.pop_front());
          armed = 0; aw_ok = 0;
        end else if (armed && cd > 0) cd--;
      end
      @(posedge clk); #1;
      axi_aw_ready_i = aw_wait < aw_hold ? 1'b0 : rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      tog = ~tog;
      axi_w_ready_i = w_toggle ? tog : rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      axi_b_valid_i = sq.size() != 0 && ((armed && cd == 0) || (early_b && aw_ok));
      axi_b_resp_i = sq.size() != 0 ? sq[0].resp : 2'b00;
      axi_b_id_i = 4'($urandom);
    end
  end

  logic m_aw = 0, m_wdone = 0, b_prev = 0;
  w_t m_e;
  always @(negedge clk) begin
    if (!reset_n) begin
      m_aw = 0; m_wdone = 0; b_prev = 0;
    end else begin
      if (axi_aw_valid_o) begin
        if (eaw.size() == 0) fail("aw_unexpected");
        else begin
          chk("aw_addr", axi_aw_addr_o, eaw[0].addr);
          chk("aw_len", axi_aw_len_o, eaw[0].len);
          chk("aw_size", axi_aw_size_o, eaw[0].size);
          chk("aw_id", axi_aw_id_o, eaw[0].id);
          if (axi_aw_ready_i) begin
            chk("aw_burst", axi_aw_burst_o, 1);
            chk("aw_const", {axi_aw_prot_o, axi_aw_cache_o, axi_aw_qos_o, axi_aw_region_o, axi_aw_lock_o, axi_aw_user_o}, 0);
            void'(eaw.pop_front());
            m_aw = 1;
          end
        end
      end
      if (axi_w_valid_o) begin
        chk("w_before_aw", m_aw, 1);
        if (axi_w_ready_i) begin
          if (ew.size() == 0) fail("w_unexpected");
          else begin
            m_e = ew.pop_front();
            chk("w_data", axi_w_data_o, m_e.data);
            chk("w_strb", axi_w_strb_o, m_e.strb);
            chk("w_last", axi_w_last_o, m_e.last);
            if (m_e.last) m_wdone = 1;
          end
        end
      end
      if (axi_b_ready_o) chk("b_ready_before_last", m_wdone, 1);
      if (b_prev || cpu_b_valid) chk("b_pulse", cpu_b_valid, b_prev);
      if (cpu_b_valid) begin
        if (eb.size() == 0) fail("b_unexpected");
        else chk("b_resp", cpu_b_resp, eb.pop_front());
      end
      b_prev = axi_b_valid_i && axi_b_ready_o;
      if (b_prev) begin m_aw = 0; m_wdone = 0; end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    reset_n = 0; cpu_aw_valid = 0; cpu_w_valid = 0; cpu_id = 0; cpu_addr = 0;
    cpu_len = 0; cpu_size = 0; cpu_w_data = 0;
    repeat (3) @(posedge clk);
    #1;
    rst_checks();
    reset_n = 1;
    @(posedge clk); #1;
    issue(4'h1, 64'h8000_0005, 2'd0, 8'd0, 2'b00, 0, -1, 0, 1, 64'hAB);
    drain();
    aw_hold = 3;
    issue(4'h2, 64'h8000_1004, 2'd2, 8'd0, 2'b00, 0, -1, 0, 1, 64'hDEAD_BEEF);
    aw_hold = 0;
    drain();
    w_toggle = 1;
    issue(4'h3, 64'h8000_2000, 2'd3, 8'd3, 2'b01, 1, -1, 1, 0, 64'h0);
    w_toggle = 0;
    issue(4'h4, 64'h8000_3002, 2'd1, 8'd0, 2'b10, 5, -1, 0, 0, 64'h0);
    issue(4'h5, 64'h8000_4007, 2'd1, 8'd0, 2'b11, 0, -1, 0, 0, 64'h0);
    drain();
    early_b = 1;
    issue(4'h6, 64'h8000_5008, 2'd3, 8'd2, 2'b10, 0, -1, 1, 0, 64'h0);
    early_b = 0;
    drain();
    issue(4'h7, 64'h8000_6000, 2'd3, 8'd3, 2'b00, 0, 1, 0, 0, 64'h0);
    issue(4'h8, 64'h8000_6003, 2'd2, 8'd0, 2'b00, 0, -1, 0, 0, 64'h0);
    drain();
    rnd_ready = 1;
    for (int i = 0; i < 40; i++) begin
      logic [7:0] len;
      logic [63:0] addr;
      logic [1:0] size;
      len = $urandom_range(0, 1) ? 8'd0 : 8'($urandom_range(1, 15));
      addr = {$urandom, $urandom};
      size = 2'($urandom);
      if (len != 0) begin addr[2:0] = 3'b000; size = 2'd3; end
      early_b = $urandom_range(0, 3) == 0;
      issue(4'($urandom), addr, size, len, 2'($urandom), $urandom_range(0, 4), -1, 1, 0, 64'h0);
    end
    early_b = 0;
    drain();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
